// File: rtl/pipelined_datapath.sv
// Five-stage F/D/E/M/W integer datapath with E-stage branch resolution,
// D-stage jumps, optional M/W bypassing and load-use / interlock stalls.
module pipelined_datapath #(
  parameter int              WIDTH      = 32,
  parameter int              FORWARDING = 1,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] PC,
  input  logic [31:0]      InstrF,
  output logic [31:0]      InstrD,
  input  logic [9:0]       CtrlD,
  output logic [WIDTH-1:0] AluOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic             MemWriteM,
  input  logic [WIDTH-1:0] ReadDataM,
  output logic             Stall,
  output logic             Flush
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       jump;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    ctrl_t            ctrl;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc_plus4;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       dest;
  } id_ex_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] write_data;
    logic [4:0]       dest;
  } ex_mem_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] read_data;
    logic [4:0]       dest;
  } mem_wb_t;

  logic [WIDTH-1:0] regs [32];

  logic             valid_d;
  logic [31:0]      instr_d;
  logic [WIDTH-1:0] pc_plus4_d;
  id_ex_t           ex;
  ex_mem_t          mem;
  mem_wb_t          wb;

  logic [WIDTH-1:0] pc_plus4_f;
  ctrl_t            ctrl_d;
  logic [4:0]       rs_d;
  logic [4:0]       rt_d;
  logic [4:0]       dest_d;
  logic [WIDTH-1:0] imm_d;
  logic [WIDTH-1:0] rd1_d;
  logic [WIDTH-1:0] rd2_d;
  id_ex_t           id_next;

  logic [WIDTH-1:0] result_w;
  logic             wb_hit;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] store_e;
  logic [WIDTH-1:0] alu_y;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic             match_e;
  logic             match_m;
  logic             hazard;
  logic             stall;
  logic             jump_go;

  assign pc_plus4_f = PC + WIDTH'(4);

  // A bubble in D must not leak whatever the controller decodes from it
  assign ctrl_d = valid_d ? ctrl_t'(CtrlD) : '0;
  assign rs_d   = instr_d[25:21];
  assign rt_d   = instr_d[20:16];
  assign dest_d = ctrl_d.reg_dst ? instr_d[15:11] : rt_d;
  assign imm_d  = {{(WIDTH-16){instr_d[15]}}, instr_d[15:0]};

  assign result_w = wb.mem_to_reg ? wb.read_data : wb.alu_out;
  assign wb_hit   = wb.reg_write && (wb.dest != 5'd0);

  always_comb begin
    rd1_d = regs[rs_d];
    rd2_d = regs[rt_d];
    if (wb_hit && wb.dest == rs_d) rd1_d = result_w;
    if (wb_hit && wb.dest == rt_d) rd2_d = result_w;
    if (rs_d == 5'd0) rd1_d = '0;
    if (rt_d == 5'd0) rd2_d = '0;
  end

  always_comb begin
    id_next          = '0;
    id_next.ctrl     = ctrl_d;
    id_next.rd1      = rd1_d;
    id_next.rd2      = rd2_d;
    id_next.imm      = imm_d;
    id_next.pc_plus4 = pc_plus4_d;
    id_next.rs       = rs_d;
    id_next.rt       = rt_d;
    id_next.dest     = dest_d;
  end

  // M takes priority over W: it holds the younger write
  always_comb begin
    src_a   = ex.rd1;
    store_e = ex.rd2;
    if (FORWARDING != 0) begin
      if (mem.reg_write && mem.dest != 5'd0 && mem.dest == ex.rs)
        src_a = mem.alu_out;
      else if (wb_hit && wb.dest == ex.rs)
        src_a = result_w;
      if (mem.reg_write && mem.dest != 5'd0 && mem.dest == ex.rt)
        store_e = mem.alu_out;
      else if (wb_hit && wb.dest == ex.rt)
        store_e = result_w;
    end
  end

  assign src_b = ex.ctrl.alu_src ? ex.imm : store_e;

  always_comb begin
    alu_y = '0;
    case (ex.ctrl.alu_ctrl)
      3'b010:  alu_y = src_a + src_b;
      3'b110:  alu_y = src_a - src_b;
      3'b000:  alu_y = src_a & src_b;
      3'b001:  alu_y = src_a | src_b;
      3'b111:  alu_y = {{(WIDTH-1){1'b0}},
                        $signed(src_a) < $signed(src_b)};
      default: alu_y = '0;
    endcase
  end

  assign branch_taken  = ex.ctrl.branch && (alu_y == '0);
  assign branch_target = ex.pc_plus4 + {ex.imm[WIDTH-3:0], 2'b00};
  assign jump_target   = {pc_plus4_d[WIDTH-1:28], instr_d[25:0], 2'b00};

  assign match_e = (ex.dest != 5'd0) &&
                   (ex.dest == rs_d || ex.dest == rt_d);
  assign match_m = (mem.dest != 5'd0) &&
                   (mem.dest == rs_d || mem.dest == rt_d);

  assign hazard = (FORWARDING != 0) ?
                  (ex.ctrl.mem_to_reg && match_e) :
                  ((ex.ctrl.reg_write && match_e) ||
                   (mem.reg_write && match_m));

  assign stall   = hazard && !branch_taken;
  assign jump_go = ctrl_d.jump && !hazard && !branch_taken;

  assign Stall      = stall;
  assign Flush      = branch_taken || jump_go;
  assign InstrD     = instr_d;
  assign AluOutM    = mem.alu_out;
  assign WriteDataM = mem.write_data;
  assign MemWriteM  = mem.mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC <= RESET_PC;
    end else begin
      unique case (1'b1)
        branch_taken: PC <= branch_target;
        stall:        PC <= PC;
        jump_go:      PC <= jump_target;
        default:      PC <= pc_plus4_f;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_d    <= 1'b0;
      instr_d    <= '0;
      pc_plus4_d <= '0;
    end else begin
      unique case (1'b1)
        branch_taken, jump_go: begin
          valid_d    <= 1'b0;
          instr_d    <= '0;
          pc_plus4_d <= '0;
        end
        stall: begin
          valid_d    <= valid_d;
          instr_d    <= instr_d;
          pc_plus4_d <= pc_plus4_d;
        end
        default: begin
          valid_d    <= 1'b1;
          instr_d    <= InstrF;
          pc_plus4_d <= pc_plus4_f;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      ex <= (branch_taken || hazard) ? '0 : id_next;

      mem.reg_write  <= ex.ctrl.reg_write;
      mem.mem_to_reg <= ex.ctrl.mem_to_reg;
      mem.mem_write  <= ex.ctrl.mem_write;
      mem.alu_out    <= alu_y;
      mem.write_data <= store_e;
      mem.dest       <= ex.dest;

      wb.reg_write  <= mem.reg_write;
      wb.mem_to_reg <= mem.mem_to_reg;
      wb.alu_out    <= mem.alu_out;
      wb.read_data  <= ReadDataM;
      wb.dest       <= mem.dest;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb.dest] <= result_w;
    end
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Scoreboard bench: a forwarding and an interlock-only instance run the same
// programs; every store is checked in order, plus PC, Stall and Flush traces.
module tb_pipelined_datapath;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] imem  [64];
  logic [31:0] dmem1 [64];
  logic [31:0] dmem0 [64];

  logic [31:0] pc1, pc0, instr_f1, instr_f0, instr_d1, instr_d0;
  logic [9:0]  ctrl_d1, ctrl_d0;
  logic [31:0] alu1, alu0, wd1, wd0, rdata1, rdata0;
  logic        mw1, mw0, stall1, stall0, flush1, flush0;

  int errors = 0;
  int checks = 0;

  logic [63:0] q1[$];
  logic [63:0] q0[$];
  logic [63:0] exp1_v, exp0_v;

  int          st1, st0, fl1;
  bit          fl_seen, fl_capt;
  logic [31:0] pc_after;

  function automatic logic [9:0] mk(bit rw, bit mr, bit mw, bit as,
                                    bit rd, bit br, bit jp,
                                    logic [2:0] alu);
    return {rw, mr, mw, as, rd, br, jp, alu};
  endfunction

  function automatic logic [9:0] ctrl_of(input logic [31:0] i);
    logic [9:0] c;
    c = '0;
    case (i[31:26])
      6'h00: begin
        case (i[5:0])
          6'h20: c = mk(1, 0, 0, 0, 1, 0, 0, 3'b010);
          6'h22: c = mk(1, 0, 0, 0, 1, 0, 0, 3'b110);
          6'h24: c = mk(1, 0, 0, 0, 1, 0, 0, 3'b000);
          6'h25: c = mk(1, 0, 0, 0, 1, 0, 0, 3'b001);
          6'h2a: c = mk(1, 0, 0, 0, 1, 0, 0, 3'b111);
          default: c = '0;
        endcase
      end
      6'h08: c = mk(1, 0, 0, 1, 0, 0, 0, 3'b010);
      6'h23: c = mk(1, 1, 0, 1, 0, 0, 0, 3'b010);
      6'h2b: c = mk(0, 0, 1, 1, 0, 0, 0, 3'b010);
      6'h04: c = mk(0, 0, 0, 0, 0, 1, 0, 3'b110);
      6'h02: c = mk(0, 0, 0, 0, 0, 0, 1, 3'b000);
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] addi(input int rt, input int rs,
                                       input int imm);
    return {6'h08, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] lw(input int rt, input int off,
                                     input int rs);
    return {6'h23, 5'(rs), 5'(rt), 16'(off)};
  endfunction
  function automatic logic [31:0] sw(input int rt, input int off,
                                     input int rs);
    return {6'h2b, 5'(rs), 5'(rt), 16'(off)};
  endfunction
  function automatic logic [31:0] beq(input int rs, input int rt,
                                      input int off);
    return {6'h04, 5'(rs), 5'(rt), 16'(off)};
  endfunction
  function automatic logic [31:0] rop(input logic [5:0] fn, input int rd,
                                      input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] jmp(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  assign instr_f1 = imem[pc1[7:2]];
  assign instr_f0 = imem[pc0[7:2]];
  assign ctrl_d1  = ctrl_of(instr_d1);
  assign ctrl_d0  = ctrl_of(instr_d0);
  assign rdata1   = dmem1[alu1[7:2]];
  assign rdata0   = dmem0[alu0[7:2]];

  pipelined_datapath #(.WIDTH(32), .FORWARDING(1), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .PC(pc1), .InstrF(instr_f1),
    .InstrD(instr_d1), .CtrlD(ctrl_d1), .AluOutM(alu1),
    .WriteDataM(wd1), .MemWriteM(mw1), .ReadDataM(rdata1),
    .Stall(stall1), .Flush(flush1)
  );

  pipelined_datapath #(.WIDTH(32), .FORWARDING(0), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .reset(reset), .PC(pc0), .InstrF(instr_f0),
    .InstrD(instr_d0), .CtrlD(ctrl_d0), .AluOutM(alu0),
    .WriteDataM(wd0), .MemWriteM(mw0), .ReadDataM(rdata0),
    .Stall(stall0), .Flush(flush0)
  );

  always @(negedge clk) begin
    if (mw1) begin
      dmem1[alu1[7:2]] = wd1;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL store fwd unexpected: addr=%h data=%h", alu1, wd1);
      end else begin
        exp1_v = q1.pop_front();
        if ({alu1, wd1} !== exp1_v) begin
          errors++;
          $display("FAIL store fwd: got %h/%h expected %h/%h",
                   alu1, wd1, exp1_v[63:32], exp1_v[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mw0) begin
      dmem0[alu0[7:2]] = wd0;
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL store ilk unexpected: addr=%h data=%h", alu0, wd0);
      end else begin
        exp0_v = q0.pop_front();
        if ({alu0, wd0} !== exp0_v) begin
          errors++;
          $display("FAIL store ilk: got %h/%h expected %h/%h",
                   alu0, wd0, exp0_v[63:32], exp0_v[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
    q1.push_back({a, d});
    q0.push_back({a, d});
  endtask

  task automatic begin_test();
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      imem[i]  = 32'h0;
      dmem1[i] = 32'h0;
      dmem0[i] = 32'h0;
    end
    dmem1[0] = 32'd7;
    dmem0[0] = 32'd7;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    st1 = 0; st0 = 0; fl1 = 0;
    fl_seen = 0; fl_capt = 0; pc_after = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (fl_seen && !fl_capt) begin
        pc_after = pc1;
        fl_capt = 1;
      end
      st1 += int'(stall1);
      st0 += int'(stall0);
      fl1 += int'(flush1);
      if (flush1) fl_seen = 1;
    end
  endtask

  task automatic drained(input string name);
    chk({name, " fwd drained"}, 64'(q1.size()), 64'd0);
    chk({name, " ilk drained"}, 64'(q0.size()), 64'd0);
  endtask

  initial begin
    // NOP stream after reset
    begin_test();
    chk("rst PC", pc1, 0);
    chk("rst InstrD", instr_d1, 0);
    chk("rst AluOutM", alu1, 0);
    chk("rst WriteDataM", wd1, 0);
    chk("rst MemWriteM", mw1, 0);
    chk("rst Stall", stall1, 0);
    chk("rst Flush", flush1, 0);
    release_reset();
    for (int k = 0; k < 6; k++) begin
      chk("nop PC fwd", pc1, 64'(4 * k));
      chk("nop PC ilk", pc0, 64'(4 * k));
      @(negedge clk);
    end

    // Back-to-back RAW dependency
    begin_test();
    imem[0] = addi(1, 0, 5);
    imem[1] = rop(6'h20, 2, 1, 1);
    imem[5] = sw(2, 0, 0);
    expect_store(32'h0, 32'd10);
    release_reset();
    run(30);
    chk("raw stall fwd", 64'(st1), 0);
    chk("raw stall ilk", 64'(st0), 2);
    drained("raw");

    // Load-use
    begin_test();
    imem[0] = lw(1, 0, 0);
    imem[1] = rop(6'h20, 2, 1, 1);
    imem[6] = sw(2, 4, 0);
    expect_store(32'h4, 32'd14);
    release_reset();
    run(30);
    chk("lu stall fwd", 64'(st1), 1);
    chk("lu stall ilk", 64'(st0), 2);
    drained("lu");

    // ALU ops, M-over-W priority, $0 never forwarded, store data bypass
    begin_test();
    imem[0]  = addi(4, 0, -3);
    imem[1]  = addi(3, 0, 12);
    imem[2]  = addi(3, 0, 6);
    imem[3]  = rop(6'h22, 5, 3, 4);
    imem[4]  = rop(6'h24, 6, 3, 4);
    imem[5]  = rop(6'h25, 7, 5, 6);
    imem[6]  = rop(6'h2a, 8, 4, 3);
    imem[7]  = rop(6'h2a, 9, 3, 4);
    imem[8]  = rop(6'h20, 0, 3, 3);
    imem[9]  = rop(6'h20, 10, 0, 4);
    imem[10] = sw(10, 20, 0);
    imem[11] = sw(5, 0, 0);
    imem[12] = sw(6, 4, 0);
    imem[13] = sw(7, 8, 0);
    imem[14] = sw(8, 12, 0);
    imem[15] = sw(9, 16, 0);
    imem[16] = sw(3, 24, 0);
    expect_store(32'd20, 32'hFFFF_FFFD);
    expect_store(32'd0,  32'd9);
    expect_store(32'd4,  32'd4);
    expect_store(32'd8,  32'd13);
    expect_store(32'd12, 32'd1);
    expect_store(32'd16, 32'd0);
    expect_store(32'd24, 32'd6);
    release_reset();
    run(50);
    drained("alu");

    // Taken branch at PC 8
    begin_test();
    imem[0] = addi(1, 0, 1);
    imem[2] = beq(0, 0, 3);
    imem[3] = addi(2, 0, 99);
    imem[4] = addi(3, 0, 99);
    imem[5] = addi(4, 0, 99);
    imem[6] = sw(2, 0, 0);
    imem[7] = sw(3, 4, 0);
    imem[8] = sw(1, 8, 0);
    imem[9] = sw(4, 12, 0);
    expect_store(32'd0,  32'd0);
    expect_store(32'd4,  32'd0);
    expect_store(32'd8,  32'd1);
    expect_store(32'd12, 32'd0);
    release_reset();
    run(30);
    chk("br flush cycles", 64'(fl1), 1);
    chk("br target PC", pc_after, 32'd24);
    chk("br stall", 64'(st1), 0);
    drained("br");

    // Branch in E beats jump in D
    begin_test();
    imem[2]  = beq(0, 0, 5);
    imem[3]  = jmp(26'h10);
    imem[4]  = addi(7, 0, 55);
    imem[8]  = addi(6, 0, 33);
    imem[13] = sw(6, 0, 0);
    imem[14] = sw(7, 4, 0);
    imem[15] = jmp(26'h0F);
    imem[16] = sw(0, 60, 0);
    expect_store(32'd0, 32'd33);
    expect_store(32'd4, 32'd0);
    release_reset();
    run(40);
    chk("br-over-jump PC", pc_after, 32'h20);
    drained("brj");

    // Jump held by a load-use stall, then taken
    begin_test();
    imem[0] = lw(1, 0, 0);
    imem[1] = jmp(26'h0200006);
    imem[2] = addi(2, 0, 77);
    imem[6] = sw(2, 0, 0);
    imem[7] = sw(1, 4, 0);
    imem[8] = jmp(26'h0200008);
    expect_store(32'd0, 32'd0);
    expect_store(32'd4, 32'd7);
    release_reset();
    run(30);
    chk("jmp stall fwd", 64'(st1), 1);
    chk("jmp stall ilk", 64'(st0), 2);
    chk("jmp target PC", pc_after, 32'h0080_0018);
    drained("jmp");

    // Reset pulsed while sw is in E
    begin_test();
    imem[0] = addi(1, 0, 9);
    imem[1] = addi(2, 0, 3);
    imem[2] = addi(3, 0, 4);
    imem[3] = sw(1, 0, 0);
    imem[4] = addi(4, 0, 5);
    release_reset();
    repeat (5) @(negedge clk);
    chk("pre-rst InstrD live", 64'(instr_d1 != 0), 1);
    reset = 1'b1;
    #1;
    chk("mid-rst PC", pc1, 0);
    chk("mid-rst InstrD", instr_d1, 0);
    chk("mid-rst AluOutM", alu1, 0);
    chk("mid-rst MemWriteM", mw1, 0);
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0] = sw(1, 0, 0);
    imem[1] = sw(3, 4, 0);
    expect_store(32'd0, 32'd0);
    expect_store(32'd4, 32'd0);
    @(negedge clk);
    chk("mid-rst MemWriteM held", mw1, 0);
    reset = 1'b0;
    chk("post-rst PC", pc1, 0);
    run(20);
    drained("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
